// File: rtl/rice_core_ex_stage_fwd.sv
// Rice core EX stage with a multi-entry forwarding history, an iterative multiplier and branch
// resolution. The ALU and LSU stay outside this block; it forwards operands out and takes results back.
module rice_core_ex_stage_fwd #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned MUL_STEP  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_id_valid,
  input  logic [1:0]      i_id_kind,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic [4:0]      i_id_rd,
  input  logic [XLEN-1:0] i_id_rs1_value,
  input  logic [XLEN-1:0] i_id_rs2_value,
  input  logic            i_id_br_invert,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_mem_valid,
  input  logic [1:0]      i_mem_done,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_stall,
  output logic            o_flush,
  output logic [XLEN-1:0] o_flush_pc,
  output logic            o_result_valid,
  output logic [4:0]      o_result_rd,
  output logic [XLEN-1:0] o_result_value
);

  localparam int unsigned K  = XLEN / MUL_STEP;
  localparam int unsigned CW = $clog2(K + 1);

  localparam logic [1:0] KIND_ALU = 2'd0;
  localparam logic [1:0] KIND_MEM = 2'd1;
  localparam logic [1:0] KIND_MUL = 2'd2;
  localparam logic [1:0] KIND_BR  = 2'd3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic            r_hv   [FWD_DEPTH];
  logic [4:0]      r_hrd  [FWD_DEPTH];
  logic [XLEN-1:0] r_hval [FWD_DEPTH];

  logic            r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [4:0]      r_mrd;

  logic            w_act;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_pp [MUL_STEP];
  logic [XLEN-1:0] w_acc_next;
  logic            w_mem_stall;
  logic            w_mul_start;
  logic            w_mul_busy;
  logic            w_mul_fin;
  logic            w_taken;
  logic            w_new_valid;
  logic [4:0]      w_new_rd;
  logic [XLEN-1:0] w_new_value;

  assign w_act = i_id_valid & i_enable;

  // Walk oldest to newest so the lowest matching index overrides.
  always_comb begin
    w_rs1 = i_id_rs1_value;
    w_rs2 = i_id_rs2_value;
    for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
      if (r_hv[k] && (r_hrd[k] == i_id_rs1) && (i_id_rs1 != 5'd0)) w_rs1 = r_hval[k];
      if (r_hv[k] && (r_hrd[k] == i_id_rs2) && (i_id_rs2 != 5'd0)) w_rs2 = r_hval[k];
    end
  end

  assign o_rs1_value = w_rs1;
  assign o_rs2_value = w_rs2;

  for (genvar g = 0; g < MUL_STEP; g++) begin : g_pp
    assign w_pp[g] = r_mplier[g] ? (r_mcand << g) : '0;
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < int'(MUL_STEP); j++) begin
      w_acc_next = w_acc_next + w_pp[j];
    end
  end

  assign o_mem_valid = w_act & (i_id_kind == KIND_MEM);
  assign w_mem_stall = o_mem_valid & (i_mem_done == 2'b00);
  assign w_mul_start = w_act & (r_state == ST_IDLE) & (i_id_kind == KIND_MUL);
  assign w_mul_busy  = (r_state == ST_BUSY) & (r_cnt > CW'(1));
  assign w_mul_fin   = (r_state == ST_BUSY) & (r_cnt == CW'(1));

  assign o_stall = i_rst_n & i_enable & (w_mem_stall | w_mul_start | w_mul_busy);

  assign w_taken    = w_act & (i_id_kind == KIND_BR) & ((w_rs1 == w_rs2) ^ i_id_br_invert);
  assign o_flush    = i_rst_n & w_taken;
  assign o_flush_pc = o_flush ? (i_id_pc + i_id_imm) : '0;

  always_comb begin
    w_new_valid = 1'b0;
    w_new_rd    = i_id_rd;
    w_new_value = i_alu_data;
    if (w_mul_fin) begin
      w_new_valid = 1'b1;
      w_new_rd    = r_mrd;
      w_new_value = w_acc_next;
    end else begin
      unique case (i_id_kind)
        KIND_ALU: w_new_valid = w_act;
        KIND_MEM: begin
          w_new_valid = w_act & i_mem_done[1];
          w_new_value = i_mem_data;
        end
        KIND_MUL: w_new_valid = 1'b0;
        KIND_BR:  w_new_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        r_hv[k]   <= 1'b0;
        r_hrd[k]  <= '0;
        r_hval[k] <= '0;
      end
    end else if (!i_enable) begin
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        r_hv[k]   <= 1'b0;
        r_hrd[k]  <= '0;
        r_hval[k] <= '0;
      end
    end else if (!o_stall) begin
      r_hv[0]   <= w_new_valid;
      r_hrd[0]  <= w_new_rd;
      r_hval[0] <= w_new_value;
      for (int k = 1; k < int'(FWD_DEPTH); k++) begin
        r_hv[k]   <= r_hv[k-1];
        r_hrd[k]  <= r_hrd[k-1];
        r_hval[k] <= r_hval[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mrd    <= '0;
    end else if (!i_enable) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_mul_start) begin
        r_mcand  <= w_rs1;
        r_mplier <= w_rs2;
        r_mrd    <= i_id_rd;
        r_acc    <= '0;
        r_cnt    <= CW'(K);
        r_state  <= ST_BUSY;
      end
    end else begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_state <= ST_IDLE;
    end
  end

  assign o_result_valid = r_hv[0];
  assign o_result_rd    = r_hrd[0];
  assign o_result_value = r_hval[0];

endmodule

// File: tb/tb_rice_core_ex_stage_fwd.sv
// Bench for rice_core_ex_stage_fwd: forwarding, multiplier latency (step 1 and 4), MEM stall,
// branch flush, enable drop and asynchronous reset, with a queue of expected newest results.
module tb_rice_core_ex_stage_fwd;

  localparam logic [1:0] KALU = 2'd0;
  localparam logic [1:0] KMEM = 2'd1;
  localparam logic [1:0] KMUL = 2'd2;
  localparam logic [1:0] KBR  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        id_valid;
  logic        id_valid4;
  logic [1:0]  kind;
  logic [31:0] pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1v, rs2v;
  logic        br_inv;
  logic [31:0] alu_data;
  logic [1:0]  mem_done;
  logic [31:0] mem_data;

  logic [31:0] o_rs1, o_rs2, o_fpc;
  logic        o_memv, o_stall, o_flush, o_rv;
  logic [4:0]  o_rrd;
  logic [31:0] o_rval;

  logic [31:0] o4_rs1, o4_rs2, o4_fpc;
  logic        o4_memv, o4_stall, o4_flush, o4_rv;
  logic [4:0]  o4_rrd;
  logic [31:0] o4_rval;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] val;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  always #5 clk = ~clk;

  rice_core_ex_stage_fwd #(.XLEN(32), .FWD_DEPTH(2), .MUL_STEP(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_id_valid(id_valid),
    .i_id_kind(kind), .i_id_pc(pc), .i_id_imm(imm), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rd(rd), .i_id_rs1_value(rs1v), .i_id_rs2_value(rs2v), .i_id_br_invert(br_inv),
    .o_rs1_value(o_rs1), .o_rs2_value(o_rs2), .i_alu_data(alu_data), .o_mem_valid(o_memv),
    .i_mem_done(mem_done), .i_mem_data(mem_data), .o_stall(o_stall), .o_flush(o_flush),
    .o_flush_pc(o_fpc), .o_result_valid(o_rv), .o_result_rd(o_rrd), .o_result_value(o_rval)
  );

  rice_core_ex_stage_fwd #(.XLEN(32), .FWD_DEPTH(2), .MUL_STEP(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_id_valid(id_valid4),
    .i_id_kind(kind), .i_id_pc(pc), .i_id_imm(imm), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rd(rd), .i_id_rs1_value(rs1v), .i_id_rs2_value(rs2v), .i_id_br_invert(br_inv),
    .o_rs1_value(o4_rs1), .o_rs2_value(o4_rs2), .i_alu_data(alu_data), .o_mem_valid(o4_memv),
    .i_mem_done(mem_done), .i_mem_data(mem_data), .o_stall(o4_stall), .o_flush(o4_flush),
    .o_flush_pc(o4_fpc), .o_result_valid(o4_rv), .o_result_rd(o4_rrd), .o_result_value(o4_rval)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic v, input logic [4:0] d, input logic [31:0] val);
    res_t e;
    e.v   = v;
    e.rd  = d;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s got=no_expected exp=queued_result", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, 64'(o_rv), 64'(e.v));
      check({tag, "_rd"}, 64'(o_rrd), 64'(e.rd));
      if (e.v) check({tag, "_value"}, 64'(o_rval), 64'(e.val));
    end
  endtask

  task automatic drive(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [31:0] v1, input logic [4:0] s2, input logic [31:0] v2,
                       input logic [31:0] alu);
    id_valid = 1'b1;
    kind     = k;
    rd       = d;
    rs1      = s1;
    rs1v     = v1;
    rs2      = s2;
    rs2v     = v2;
    alu_data = alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; id_valid = 1'b1; id_valid4 = 1'b0; kind = KMUL;
    pc = '0; imm = '0; rs1 = '0; rs2 = '0; rd = '0; rs1v = '0; rs2v = '0;
    br_inv = 1'b0; alu_data = '0; mem_done = '0; mem_data = '0;

    // In reset with a MUL presented: outputs must read 0
    #3;
    check("rst_valid", 64'(o_rv), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_flush", 64'(o_flush), 64'd0);
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Newest wins, then aged out
    drive(KALU, 5'd5, 5'd0, 32'd0, 5'd0, 32'd0, 32'd10); push(1'b1, 5'd5, 32'd10);
    tick(); sb_pop("alu_x5a");
    drive(KALU, 5'd5, 5'd0, 32'd0, 5'd0, 32'd0, 32'd20); push(1'b1, 5'd5, 32'd20);
    tick(); sb_pop("alu_x5b");
    drive(KALU, 5'd6, 5'd5, 32'd0, 5'd0, 32'd0, 32'd1); #1;
    check("fwd_newest", 64'(o_rs1), 64'd20);
    push(1'b1, 5'd6, 32'd1); tick(); sb_pop("alu_x6");
    drive(KALU, 5'd7, 5'd0, 32'd0, 5'd0, 32'd0, 32'd2); push(1'b1, 5'd7, 32'd2);
    tick(); sb_pop("alu_x7");
    drive(KALU, 5'd8, 5'd5, 32'h55, 5'd6, 32'h0, 32'd3); #1;
    check("fwd_aged", 64'(o_rs1), 64'h55);
    check("fwd_h1", 64'(o_rs2), 64'd1);
    push(1'b1, 5'd8, 32'd3); tick(); sb_pop("alu_x8");

    // x0 result is valid but never forwarded
    drive(KALU, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd7); push(1'b1, 5'd0, 32'd7);
    tick(); sb_pop("alu_x0");
    drive(KALU, 5'd9, 5'd0, 32'd0, 5'd0, 32'd0, 32'd4); #1;
    check("fwd_x0", 64'(o_rs1), 64'd0);
    push(1'b1, 5'd9, 32'd4); tick(); sb_pop("alu_x9");

    // MUL_STEP=1: 32 stall cycles, result on the 33rd cycle
    drive(KMUL, 5'd10, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd3, 32'd0);
    push(1'b1, 5'd10, 32'hFFFF_FFFD);
    #1;
    n = 0;
    while (o_stall && n < 40) begin n++; tick(); end
    check("mul1_stalls", 64'(n), 64'd32);
    check("mul1_frozen", 64'(o_rrd), 64'd9);
    tick(); sb_pop("mul1_res");
    drive(KALU, 5'd16, 5'd10, 32'd0, 5'd0, 32'd0, 32'd0); #1;
    check("fwd_mul", 64'(o_rs1), 64'hFFFF_FFFD);
    push(1'b1, 5'd16, 32'd0); tick(); sb_pop("alu_x16");

    // MUL_STEP=4 instance: 8 stall cycles
    id_valid = 1'b0; id_valid4 = 1'b1; kind = KMUL; rd = 5'd10;
    rs1 = 5'd1; rs1v = 32'hFFFF_FFFF; rs2 = 5'd2; rs2v = 32'd3;
    #1;
    n = 0;
    while (o4_stall && n < 20) begin n++; tick(); end
    check("mul4_stalls", 64'(n), 64'd8);
    tick();
    id_valid4 = 1'b0;
    check("mul4_valid", 64'(o4_rv), 64'd1);
    check("mul4_value", 64'(o4_rval), 64'hFFFF_FFFD);

    // Load: 3 stall cycles with history frozen, then data, then a store
    drive(KALU, 5'd12, 5'd0, 32'd0, 5'd0, 32'd0, 32'h77); push(1'b1, 5'd12, 32'h77);
    tick(); sb_pop("alu_x12");
    drive(KMEM, 5'd11, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0); mem_done = 2'b00; #1;
    check("mem_valid", 64'(o_memv), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("mem_stall", 64'(o_stall), 64'd1);
      tick();
      check("mem_frozen_rd", 64'(o_rrd), 64'd12);
      check("mem_frozen_val", 64'(o_rval), 64'h77);
    end
    mem_done = 2'b10; mem_data = 32'h1234; #1;
    check("mem_nostall", 64'(o_stall), 64'd0);
    push(1'b1, 5'd11, 32'h1234); tick(); sb_pop("load");
    drive(KMEM, 5'd13, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0); mem_done = 2'b01;
    push(1'b0, 5'd13, 32'd0); tick(); sb_pop("store");
    mem_done = 2'b00;

    // BEQ with x3 forwarded
    drive(KALU, 5'd3, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5); push(1'b1, 5'd3, 32'd5);
    tick(); sb_pop("alu_x3");
    drive(KBR, 5'd20, 5'd3, 32'd0, 5'd4, 32'd5, 32'd0);
    pc = 32'h100; imm = 32'h20; br_inv = 1'b0; #1;
    check("beq_flush", 64'(o_flush), 64'd1);
    check("beq_pc", 64'(o_fpc), 64'h120);
    check("beq_stall", 64'(o_stall), 64'd0);
    br_inv = 1'b1; #1;
    check("bne_flush", 64'(o_flush), 64'd0);
    check("bne_pc", 64'(o_fpc), 64'd0);
    push(1'b0, 5'd20, 32'd0); tick(); sb_pop("branch");
    br_inv = 1'b0;

    // Enable drop mid-MUL
    drive(KMUL, 5'd14, 5'd0, 32'd7, 5'd0, 32'd9, 32'd0);
    tick(); tick();
    check("mid_mul_stall", 64'(o_stall), 64'd1);
    enable = 1'b0; #1;
    check("en_low_stall", 64'(o_stall), 64'd0);
    tick();
    check("en_low_clear", 64'(o_rv), 64'd0);
    enable = 1'b1;
    drive(KALU, 5'd15, 5'd3, 32'hAA, 5'd0, 32'd0, 32'h42); #1;
    check("en_low_idle", 64'(o_stall), 64'd0);
    check("en_low_hist", 64'(o_rs1), 64'hAA);
    push(1'b1, 5'd15, 32'h42); tick(); sb_pop("alu_x15");

    // Asynchronous reset mid-MUL
    drive(KMUL, 5'd17, 5'd0, 32'd3, 5'd0, 32'd4, 32'd0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(o_rv), 64'd0);
    check("arst_rd", 64'(o_rrd), 64'd0);
    check("arst_value", 64'(o_rval), 64'd0);
    check("arst_stall", 64'(o_stall), 64'd0);
    check("arst_flush", 64'(o_flush), 64'd0);
    id_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("arst_idle", 64'(o_stall), 64'd0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
